// File: rtl/sim_run_ctrl.sv
// Simulation run controller: DUT reset sequencing, RUN cycle counter, watchdog,
// halt/exit-code capture and an 8N1 serializer driving the DUT UART Rx line.
module sim_run_ctrl #(
  parameter int          RESET_CYCLES   = 25,
  parameter int unsigned TIMEOUT_CYCLES = 150_000_000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned BAUD_DIV       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_valid,
  input  logic [7:0]       halt_code,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             dut_rst,
  output logic             rx,
  output logic             running,
  output logic             done,
  output logic             timed_out,
  output logic [7:0]       exit_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned RST_EFF  = (RESET_CYCLES < 1) ? 32'd1 : 32'(RESET_CYCLES);
  localparam int unsigned BAUD_EFF = (BAUD_DIV < 1) ? 32'd1 : BAUD_DIV;
  localparam int unsigned RST_W    = (RST_EFF > 1) ? $clog2(RST_EFF) : 1;
  localparam int unsigned BAUD_W   = (BAUD_EFF > 1) ? $clog2(BAUD_EFF) : 1;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d, timed_out_d, dut_rst_d, running_d, tx_ready_d, rx_d;
  logic [7:0]         exit_d;
  logic               busy_q, busy_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic [8:0]         sh_q, sh_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      exit_code   <= 8'h00;
      dut_rst     <= 1'b1;
      running     <= 1'b0;
      tx_ready    <= 1'b0;
      rx          <= 1'b1;
      busy_q      <= 1'b0;
      baud_q      <= '0;
      bit_q       <= 4'd0;
      sh_q        <= 9'h1FF;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_count <= cnt_d;
      done        <= done_d;
      timed_out   <= timed_out_d;
      exit_code   <= exit_d;
      dut_rst     <= dut_rst_d;
      running     <= running_d;
      tx_ready    <= tx_ready_d;
      rx          <= rx_d;
      busy_q      <= busy_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cnt_d       = cycle_count;
    done_d      = done;
    timed_out_d = timed_out;
    exit_d      = exit_code;
    busy_d      = busy_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_d        = rx;

    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == RST_W'(RST_EFF - 1)) state_d = S_RUN;
        else                                  rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      S_RUN: begin
        // Halt takes priority over a simultaneous watchdog expiry
        if (halt_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          exit_d  = halt_code;
        end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
          exit_d      = 8'hFF;
        end else if (cycle_count != '1) begin
          cnt_d = cycle_count + CNT_W'(1);
        end
      end
      S_DONE:  ;
      default: state_d = S_RESET;
    endcase

    // Serializer: bit 0 is the start bit, bits 1..8 data LSB first, bit 9 stop
    if (tx_valid && tx_ready) begin
      busy_d = 1'b1;
      baud_d = '0;
      bit_d  = 4'd0;
      sh_d   = {1'b1, tx_data};
      rx_d   = 1'b0;
    end else if (busy_q) begin
      if (baud_q == BAUD_W'(BAUD_EFF - 1)) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          rx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end

    dut_rst_d  = (state_d == S_RESET);
    running_d  = (state_d == S_RUN);
    tx_ready_d = (state_d == S_RUN) && !busy_d;
  end

endmodule
